// File: rtl/dma_copy_ctrl.sv
// IO-mapped block-copy DMA: moves CNT bytes from SRC to DST on the data-space RAM
// port, using only cycles in which the core is not accessing RAM itself.
module dma_copy_ctrl #(
    parameter     PLATFORM          = "iCE40UP",
    parameter int BUS_ADDR_DATA_LEN = 8,
    parameter int ADDR_BASE         = 'hE0,
    parameter int DATA_ADDR_WIDTH   = 16,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
    input  logic                         wr,
    input  logic                         rd,
    input  logic [7:0]                   bus_in,
    output logic [7:0]                   bus_out,
    input  logic                         core_busy,
    output logic                         dma_own,
    output logic [DATA_ADDR_WIDTH-1:0]   dma_addr,
    output logic                         dma_re,
    output logic                         dma_we,
    output logic [7:0]                   dma_d_out,
    input  logic [7:0]                   dma_d_in,
    output logic                         intr,
    input  logic                         int_rst
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_CAP  = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [BUS_ADDR_DATA_LEN-1:0] BASE = BUS_ADDR_DATA_LEN'(ADDR_BASE);

    logic [2:0]                   state;
    logic [DATA_ADDR_WIDTH-1:0]   src;
    logic [DATA_ADDR_WIDTH-1:0]   dst;
    logic [CNT_WIDTH-1:0]         cnt;
    logic                         ie;
    logic                         done_flag;
    logic [7:0]                   data_buf;

    logic [BUS_ADDR_DATA_LEN-1:0] offset;
    logic                         hit;
    logic [2:0]                   reg_sel;
    logic [15:0]                  src16;
    logic [15:0]                  dst16;
    logic [15:0]                  cnt16;
    logic                         busy;
    logic                         rd_go;
    logic                         wr_go;
    logic                         ctrl_wr;
    logic                         reg_wr;

    assign offset  = addr - BASE;
    assign hit     = (offset < BUS_ADDR_DATA_LEN'(7));
    assign reg_sel = offset[2:0];
    assign src16   = 16'(src);
    assign dst16   = 16'(dst);
    assign cnt16   = 16'(cnt);

    // BUSY stays visible through the DONE cycle and drops as the FSM returns to IDLE.
    assign busy    = (state != ST_IDLE);
    assign rd_go   = (state == ST_RD) && !core_busy;
    assign wr_go   = (state == ST_WR) && !core_busy;
    assign ctrl_wr = wr && hit && (reg_sel == 3'd6);
    assign reg_wr  = wr && hit && !busy;

    // The core always wins the RAM port; the DMA only grabs cycles it leaves free.
    assign dma_own   = rd_go || wr_go;
    assign dma_re    = rd_go;
    assign dma_we    = wr_go;
    assign dma_addr  = rd_go ? src : (wr_go ? dst : '0);
    assign dma_d_out = wr_go ? data_buf : 8'h00;

    always_comb begin
        bus_out = 8'h00;
        if (rd && hit) begin
            case (reg_sel)
                3'd0:    bus_out = src16[7:0];
                3'd1:    bus_out = src16[15:8];
                3'd2:    bus_out = dst16[7:0];
                3'd3:    bus_out = dst16[15:8];
                3'd4:    bus_out = cnt16[7:0];
                3'd5:    bus_out = cnt16[15:8];
                3'd6:    bus_out = {done_flag, 5'b00000, ie, busy};
                default: bus_out = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            src       <= '0;
            dst       <= '0;
            cnt       <= '0;
            ie        <= 1'b0;
            done_flag <= 1'b0;
            data_buf  <= 8'h00;
            intr      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctrl_wr && bus_in[0])
                        state <= (cnt == '0) ? ST_DONE : ST_RD;
                end
                ST_RD: begin
                    if (!core_busy)
                        state <= ST_CAP;
                end
                ST_CAP: begin
                    data_buf <= dma_d_in;
                    state    <= ST_WR;
                end
                ST_WR: begin
                    if (!core_busy) begin
                        src   <= src + DATA_ADDR_WIDTH'(1);
                        dst   <= dst + DATA_ADDR_WIDTH'(1);
                        cnt   <= cnt - CNT_WIDTH'(1);
                        state <= (cnt == CNT_WIDTH'(1)) ? ST_DONE : ST_RD;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            // Address/count registers are frozen while a transfer is running.
            if (reg_wr) begin
                case (reg_sel)
                    3'd0:    src <= DATA_ADDR_WIDTH'({src16[15:8], bus_in});
                    3'd1:    src <= DATA_ADDR_WIDTH'({bus_in, src16[7:0]});
                    3'd2:    dst <= DATA_ADDR_WIDTH'({dst16[15:8], bus_in});
                    3'd3:    dst <= DATA_ADDR_WIDTH'({bus_in, dst16[7:0]});
                    3'd4:    cnt <= CNT_WIDTH'({cnt16[15:8], bus_in});
                    3'd5:    cnt <= CNT_WIDTH'({bus_in, cnt16[7:0]});
                    default: ;
                endcase
            end

            if (ctrl_wr)
                ie <= bus_in[1];

            if (state == ST_DONE)
                done_flag <= 1'b1;
            else if (ctrl_wr && bus_in[7])
                done_flag <= 1'b0;

            // A completion in the same cycle as an acknowledge keeps the request raised.
            if ((state == ST_DONE) && ie)
                intr <= 1'b1;
            else if (int_rst || (ctrl_wr && bus_in[7]))
                intr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dma_copy_ctrl.sv
// Randomized bench for dma_copy_ctrl: a transaction-level copy model predicts every
// RAM access and the completion time, and a per-cycle monitor checks the port.
module tb_dma_copy_ctrl;

    localparam logic [7:0] BASE = 8'hE0;
    localparam logic [7:0] CTRL = 8'hE6;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  addr;
    logic        wr;
    logic        rd;
    logic [7:0]  bus_in;
    logic [7:0]  bus_out;
    logic        core_busy;
    logic        dma_own;
    logic [15:0] dma_addr;
    logic        dma_re;
    logic        dma_we;
    logic [7:0]  dma_d_out;
    logic [7:0]  dma_d_in;
    logic        intr;
    logic        int_rst;

    always #5 clk = ~clk;

    dma_copy_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wr        (wr),
        .rd        (rd),
        .bus_in    (bus_in),
        .bus_out   (bus_out),
        .core_busy (core_busy),
        .dma_own   (dma_own),
        .dma_addr  (dma_addr),
        .dma_re    (dma_re),
        .dma_we    (dma_we),
        .dma_d_out (dma_d_out),
        .dma_d_in  (dma_d_in),
        .intr      (intr),
        .int_rst   (int_rst)
    );

    typedef struct packed {
        logic        is_rd;
        logic [15:0] addr;
        logic [7:0]  data;
    } acc_t;

    acc_t        exp_q[$];
    acc_t        mon_e;
    int          vectors = 0;
    int          miscompares = 0;
    bit          mon_en = 1'b0;

    // Bench-side RAM seen by the DUT, plus an independent model memory.
    logic [7:0]  ram [0:65535];
    bit          ram_w [0:65535];
    logic [7:0]  mdl [0:65535];
    bit          mdl_w [0:65535];
    logic        tb_we;
    logic [15:0] tb_wa;
    logic [7:0]  tb_wd;

    logic [15:0] cur_src, cur_dst, cur_cnt;

    function automatic logic [7:0] initVal(logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ramRead(logic [15:0] a);
        return ram_w[a] ? ram[a] : initVal(a);
    endfunction

    function automatic logic [7:0] mdlRead(logic [15:0] a);
        return mdl_w[a] ? mdl[a] : initVal(a);
    endfunction

    always @(posedge clk) begin
        if (tb_we) begin
            ram[tb_wa]   <= tb_wd;
            ram_w[tb_wa] <= 1'b1;
        end
        if (dma_own && dma_we) begin
            ram[dma_addr]   <= dma_d_out;
            ram_w[dma_addr] <= 1'b1;
        end
        dma_d_in <= (dma_own && dma_re) ? ramRead(dma_addr) : 8'($urandom);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle the DUT owns the RAM it must perform the next predicted access.
    always @(negedge clk) begin
        if (mon_en) begin
            if (dma_own) begin
                checkOutput("core_priority", 32'(core_busy), 32'd0);
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_access", 32'(exp_q.size()), 32'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("acc_re", 32'(dma_re), 32'(mon_e.is_rd));
                    checkOutput("acc_we", 32'(dma_we), 32'(!mon_e.is_rd));
                    checkOutput("acc_addr", 32'(dma_addr), 32'(mon_e.addr));
                    if (!mon_e.is_rd)
                        checkOutput("acc_data", 32'(dma_d_out), 32'(mon_e.data));
                end
            end else begin
                checkOutput("idle_port", {6'd0, dma_re, dma_we, dma_addr, dma_d_out}, 32'd0);
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d);
        addr   = a;
        bus_in = d;
        wr     = 1'b1;
        @(posedge clk);
        #1;
        wr     = 1'b0;
        bus_in = 8'h00;
    endtask

    task automatic ioRead(input logic [7:0] a, output logic [7:0] d);
        addr = a;
        rd   = 1'b1;
        #1;
        d    = bus_out;
        rd   = 1'b0;
    endtask

    task automatic checkReg(input string name, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] v;
        ioRead(a, v);
        checkOutput(name, 32'(v), 32'(exp));
    endtask

    task automatic checkReg16(input string name, input logic [7:0] a, input logic [15:0] exp);
        logic [7:0] lo, hi;
        ioRead(a, lo);
        ioRead(a + 8'd1, hi);
        checkOutput(name, {16'd0, hi, lo}, 32'(exp));
    endtask

    task automatic ramPoke(input logic [15:0] a, input logic [7:0] d);
        tb_we = 1'b1;
        tb_wa = a;
        tb_wd = d;
        @(posedge clk);
        #1;
        tb_we    = 1'b0;
        mdl[a]   = d;
        mdl_w[a] = 1'b1;
    endtask

    task automatic setupRegs(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
        applyStimulus(BASE + 8'd0, s[7:0]);
        applyStimulus(BASE + 8'd1, s[15:8]);
        applyStimulus(BASE + 8'd2, d[7:0]);
        applyStimulus(BASE + 8'd3, d[15:8]);
        applyStimulus(BASE + 8'd4, n[7:0]);
        applyStimulus(BASE + 8'd5, n[15:8]);
        cur_src = s;
        cur_dst = d;
        cur_cnt = n;
    endtask

    // Ascending byte-by-byte copy, so overlapping regions see already-copied bytes.
    task automatic startCopy(input logic ie);
        logic [15:0] s, d;
        logic [7:0]  v;
        for (int i = 0; i < int'(cur_cnt); i++) begin
            s = cur_src + 16'(i);
            d = cur_dst + 16'(i);
            v = mdlRead(s);
            exp_q.push_back('{is_rd: 1'b1, addr: s, data: 8'h00});
            exp_q.push_back('{is_rd: 1'b0, addr: d, data: v});
            mdl[d]   = v;
            mdl_w[d] = 1'b1;
        end
        cur_src = cur_src + cur_cnt;
        cur_dst = cur_dst + cur_cnt;
        applyStimulus(CTRL, {6'd0, ie, 1'b1});
    endtask

    function automatic logic busyFor(input int mode, input int c);
        if (mode == 1)
            return ((c >= 1 && c <= 5) || (c >= 8 && c <= 12));
        if (mode == 2)
            return ($urandom_range(0, 2) == 0);
        return 1'b0;
    endfunction

    // Counts clock edges from the start write until DONE reads back as set.
    task automatic waitDone(input int mode, input int max, output int cycles, output int busy_n);
        logic [7:0] v;
        v         = 8'h00;
        cycles    = 0;
        busy_n    = 0;
        core_busy = busyFor(mode, 1);
        if (core_busy) busy_n++;
        while (cycles < max) begin
            @(posedge clk);
            #1;
            cycles++;
            ioRead(CTRL, v);
            if (v[7]) break;
            core_busy = busyFor(mode, cycles + 1);
            if (core_busy) busy_n++;
        end
        core_busy = 1'b0;
        if (!v[7])
            checkOutput("done_timeout", 32'(v[7]), 32'd1);
    endtask

    task automatic checkFinal(input logic ie, input int n, input logic [15:0] d0);
        checkReg16("final_src", BASE + 8'd0, cur_src);
        checkReg16("final_dst", BASE + 8'd2, cur_dst);
        checkReg16("final_cnt", BASE + 8'd4, 16'h0000);
        checkReg("final_ctrl", CTRL, {1'b1, 5'd0, ie, 1'b0});
        checkOutput("final_intr", 32'(intr), 32'(ie));
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < n; i++)
            checkOutput("mem_copy", 32'(ramRead(d0 + 16'(i))), 32'(mdlRead(d0 + 16'(i))));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    logic [15:0] s_r, d_r;
    int          n_r, cyc, bn;
    logic        ie_r;
    logic [7:0]  rv;

    initial begin
        rst = 1'b1; addr = 8'h00; wr = 1'b0; rd = 1'b0; bus_in = 8'h00;
        core_busy = 1'b0; int_rst = 1'b0; tb_we = 1'b0; tb_wa = 16'h0; tb_wd = 8'h0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_port", {5'd0, dma_own, dma_re, dma_we, dma_addr, dma_d_out}, 32'd0);
        checkOutput("rst_intr", 32'(intr), 32'd0);
        checkReg("rst_ctrl", CTRL, 8'h00);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Register access.
        setupRegs(16'h0200, 16'h0300, 16'h0004);
        applyStimulus(CTRL, 8'h02);
        checkReg16("reg_src", BASE + 8'd0, 16'h0200);
        checkReg16("reg_dst", BASE + 8'd2, 16'h0300);
        @(posedge clk);
        #1;
        checkReg16("reg_cnt", BASE + 8'd4, 16'h0004);
        checkReg("reg_ctrl", CTRL, 8'h02);
        checkReg("unmapped_hi", 8'hE7, 8'h00);
        checkReg("unmapped_lo", 8'hDF, 8'h00);
        addr = BASE;
        #1;
        checkOutput("no_rd_zero", 32'(bus_out), 32'd0);
        @(posedge clk);
        #1;

        // Copy with idle core.
        ramPoke(16'h0200, 8'h11);
        ramPoke(16'h0201, 8'h22);
        ramPoke(16'h0202, 8'h33);
        ramPoke(16'h0203, 8'h44);
        startCopy(1'b1);
        waitDone(0, 100, cyc, bn);
        checkOutput("copy_cycles", 32'(cyc), 32'(3 * 4 + 1));
        checkFinal(1'b1, 4, 16'h0300);
        checkOutput("copy_lit_first", 32'(ramRead(16'h0300)), 32'h11);
        checkOutput("copy_lit_last", 32'(ramRead(16'h0303)), 32'h44);
        checkOutput("copy_lit_src", 32'(cur_src), 32'h0204);
        applyStimulus(CTRL, 8'h82);
        checkOutput("w1c_intr", 32'(intr), 32'd0);
        checkReg("w1c_ctrl", CTRL, 8'h02);

        // Core contention during a read and during a write.
        setupRegs(16'h0200, 16'h0400, 16'h0004);
        startCopy(1'b1);
        waitDone(1, 200, cyc, bn);
        checkOutput("contention_cycles", 32'(cyc), 32'd23);
        checkFinal(1'b1, 4, 16'h0400);
        applyStimulus(CTRL, 8'h80);

        // Zero-length start.
        setupRegs(16'h0250, 16'h0350, 16'h0000);
        startCopy(1'b1);
        waitDone(0, 20, cyc, bn);
        checkOutput("cnt0_cycles", 32'(cyc), 32'd1);
        checkFinal(1'b1, 0, 16'h0350);

        // Wrap of SRC, interrupt acknowledge, DONE clear.
        applyStimulus(CTRL, 8'h80);
        ramPoke(16'hFFFF, 8'hA5);
        ramPoke(16'h0000, 8'h5A);
        setupRegs(16'hFFFF, 16'h0500, 16'h0002);
        startCopy(1'b1);
        waitDone(0, 50, cyc, bn);
        checkFinal(1'b1, 2, 16'h0500);
        checkOutput("wrap_lit_src", 32'(cur_src), 32'h0001);
        checkOutput("wrap_lit_byte", 32'(ramRead(16'h0501)), 32'h5A);
        @(posedge clk);
        #1;
        int_rst = 1'b1;
        @(posedge clk);
        #1;
        int_rst = 1'b0;
        checkOutput("ack_intr", 32'(intr), 32'd0);
        checkReg("ack_ctrl", CTRL, 8'h82);
        applyStimulus(CTRL, 8'h80);
        checkReg("clear_ctrl", CTRL, 8'h00);

        // Writes during a transfer must not disturb it.
        setupRegs(16'h0600, 16'h0700, 16'h0006);
        startCopy(1'b1);
        applyStimulus(BASE + 8'd0, 8'h99);
        applyStimulus(BASE + 8'd4, 8'h01);
        applyStimulus(CTRL, 8'h03);
        checkReg("busy_ctrl", CTRL, 8'h03);
        checkReg("busy_src_live", BASE + 8'd0, 8'h01);
        checkReg("busy_cnt_live", BASE + 8'd4, 8'h05);
        waitDone(0, 100, cyc, bn);
        checkOutput("busy_cycles", 32'(cyc), 32'(3 * 6 + 1 - 3));
        checkFinal(1'b1, 6, 16'h0700);
        applyStimulus(CTRL, 8'h80);

        // Randomized copies with random core traffic and overlapping windows.
        for (int t = 0; t < 8; t++) begin
            s_r  = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                               : 16'h1000 + 16'($urandom_range(0, 255));
            d_r  = s_r + 16'($urandom_range(0, 16)) - 16'd8;
            n_r  = $urandom_range(0, 12);
            ie_r = 1'($urandom_range(0, 1));
            setupRegs(s_r, d_r, 16'(n_r));
            startCopy(ie_r);
            waitDone(2, 3 * n_r + 300, cyc, bn);
            checkOutput("rand_cycles", 32'(cyc >= 3 * n_r + 1 && cyc <= 3 * n_r + 1 + bn), 32'd1);
            checkFinal(ie_r, n_r, d_r);
            applyStimulus(CTRL, 8'h80);
            checkOutput("rand_clear_intr", 32'(intr), 32'd0);
            checkReg("rand_clear_ctrl", CTRL, 8'h00);
        end

        // Reset in the middle of a transfer: two bytes written, the third not.
        setupRegs(16'h0900, 16'h0A00, 16'h0008);
        startCopy(1'b1);
        repeat (7) @(posedge clk);
        #4;
        rst = 1'b0;
        #1;
        checkOutput("abort_port", {5'd0, dma_own, dma_re, dma_we, dma_addr, dma_d_out}, 32'd0);
        checkOutput("abort_intr", 32'(intr), 32'd0);
        checkReg16("abort_src", BASE + 8'd0, 16'h0000);
        checkReg16("abort_dst", BASE + 8'd2, 16'h0000);
        checkReg16("abort_cnt", BASE + 8'd4, 16'h0000);
        checkReg("abort_ctrl", CTRL, 8'h00);
        checkOutput("abort_byte0", 32'(ramRead(16'h0A00)), 32'(initVal(16'h0900)));
        checkOutput("abort_byte1", 32'(ramRead(16'h0A01)), 32'(initVal(16'h0901)));
        checkOutput("abort_byte2", 32'(ramRead(16'h0A02)), 32'(initVal(16'h0A02)));
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("post_reset_own", 32'(dma_own), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
